// File: rtl/uart_rx_engine_if.sv
// Receive-side character bus from the UART RX engine to the receive FIFO push port.
// Data_Rdy is a one-cycle valid strobe with no ready: the FIFO must take Data_Out/Rx_Error in that cycle.
interface uart_rx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data_Out;
    logic                 Data_Rdy;
    logic [2:0]           Rx_Error;
    logic                 Rx_Busy;
    logic [2:0]           Rx_State;

    modport master (output Data_Out, Data_Rdy, Rx_Error, Rx_Busy, Rx_State);
    modport slave  (input  Data_Out, Data_Rdy, Rx_Error, Rx_Busy, Rx_State);
endinterface

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: start/data(MSB first)/even parity/stop recovery with
// break, parity and frame error flags, one-cycle Data_Rdy per character.
module uart_rx_engine #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Rx,
    uart_rx_engine_if.master  rx_if
);
    localparam int DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        DONE    = 3'd5,
        BRKWAIT = 3'd6
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        div_cnt;
    logic                 tick;
    logic [SW-1:0]        sc;
    logic [3:0]           bc;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, par_err, frm_err, all_zero, brk_q;

    assign rx_if.Rx_State = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    // Divider is parked in IDLE so the first tick lands DIV clocks after the start edge.
    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                        div_cnt <= '0;
        else if (state == IDLE || tick)    div_cnt <= '0;
        else                               div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            sc             <= '0;
            bc             <= '0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            par_err        <= 1'b0;
            frm_err        <= 1'b0;
            all_zero       <= 1'b0;
            brk_q          <= 1'b0;
            rx_if.Data_Out <= '0;
            rx_if.Data_Rdy <= 1'b0;
            rx_if.Rx_Error <= 3'b000;
            rx_if.Rx_Busy  <= 1'b0;
        end else begin
            rx_if.Data_Rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        sc    <= '0;
                    end
                end
                START: if (tick) begin
                    if (sc == HALF_LAST) begin
                        sc       <= '0;
                        bc       <= '0;
                        par_acc  <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        all_zero <= 1'b1;
                        if (!rx_s) begin
                            rx_if.Rx_Busy <= 1'b1;
                            state         <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (sc == FULL_LAST) begin
                        sc      <= '0;
                        shreg   <= DATA_BITS'({shreg, rx_s});
                        par_acc <= par_acc ^ rx_s;
                        if (rx_s) all_zero <= 1'b0;
                        if (bc == DATA_LAST) begin
                            bc    <= '0;
                            state <= (PARITY_BIT != 0) ? PARITY : STOP;
                        end else begin
                            bc <= bc + 1'b1;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    if (sc == FULL_LAST) begin
                        sc      <= '0;
                        par_err <= (rx_s != par_acc);
                        if (rx_s) all_zero <= 1'b0;
                        state   <= STOP;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (sc == FULL_LAST) begin
                        sc <= '0;
                        if (bc == STOP_LAST) begin
                            // Results are loaded on the way into DONE so they are valid during DONE.
                            brk_q          <= all_zero && !rx_s;
                            rx_if.Data_Rdy <= 1'b1;
                            rx_if.Rx_Busy  <= 1'b0;
                            if (all_zero && !rx_s) begin
                                rx_if.Data_Out <= '0;
                                rx_if.Rx_Error <= 3'b001;
                            end else begin
                                rx_if.Data_Out <= shreg;
                                rx_if.Rx_Error <= {frm_err | !rx_s, par_err, 1'b0};
                            end
                            state <= DONE;
                        end else begin
                            bc <= bc + 1'b1;
                            if (!rx_s) frm_err  <= 1'b1;
                            else       all_zero <= 1'b0;
                        end
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                DONE: begin
                    sc    <= '0;
                    state <= brk_q ? BRKWAIT : IDLE;
                end
                BRKWAIT: if (tick) begin
                    if (!rx_s) begin
                        sc <= '0;
                    end else if (sc == FULL_LAST) begin
                        sc    <= '0;
                        state <= IDLE;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine at DIV=10 (160-clock bits), 8 data bits,
// even parity, two stop bits.
module tb_uart_rx_engine;
    localparam int BIT = 160;

    logic Clk, Rst_n, Rx;
    uart_rx_engine_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_engine #(
        .SYSCLK_RATE(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .rx_if(rx_if)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- monitor ----------------
    logic [10:0] got_mem [256];
    int          got_wr = 0;
    int          consec_viol = 0;
    int          busy_rises = 0;
    int          busy_cnt = 0;
    int          last_busy = 0;
    logic        rdy_prev = 1'b0;
    logic        busy_prev = 1'b0;

    always @(negedge Clk) begin
        if (rx_if.Data_Rdy) begin
            got_mem[got_wr % 256] = {rx_if.Rx_Error, rx_if.Data_Out};
            got_wr = got_wr + 1;
            if (rdy_prev) consec_viol = consec_viol + 1;
        end
        if (rx_if.Rx_Busy) begin
            if (!busy_prev) busy_rises = busy_rises + 1;
            busy_cnt = busy_cnt + 1;
        end else if (busy_prev) begin
            last_busy = busy_cnt;
            busy_cnt  = 0;
        end
        rdy_prev  = rx_if.Data_Rdy;
        busy_prev = rx_if.Rx_Busy;
    end

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];
    int          got_rd = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drain(input string name);
        logic [10:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors = vectors + 1;
            if (got_rd == got_wr) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: no Data_Rdy, expected err/data 0x%0h", name, e);
            end else begin
                if (got_mem[got_rd % 256] !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s: got err/data 0x%0h, expected 0x%0h", name, got_mem[got_rd % 256], e);
                end
                got_rd = got_rd + 1;
            end
        end
        while (got_rd != got_wr) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL %s: extra Data_Rdy err/data 0x%0h, expected none", name, got_mem[got_rd % 256]);
            got_rd = got_rd + 1;
        end
    endtask

    // Reference: what the receiver must report for a frame, from the line bits alone.
    function automatic logic [10:0] model(input logic [7:0] d, input logic par, input logic [1:0] st);
        logic [2:0] err;
        if ($countones(d) + int'(par) + $countones(st) == 0) return {3'b001, 8'h00};
        err[0] = 1'b0;
        err[1] = (($countones(d) + int'(par)) % 2) != 0;
        err[2] = (st != 2'b11);
        return {err, d};
    endfunction

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b);
        Rx = b;
        repeat (BIT) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic [1:0] st);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(par);
        send_bit(st[1]);
        send_bit(st[0]);
        Rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] st;
        logic [7:0] exp_data;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rises0;
        logic [7:0] d;
        logic       p;
        logic [1:0] s;

        tbl[0] = '{8'hA5, 1'b0, 2'b11, 8'hA5, 3'b000};
        tbl[1] = '{8'hAA, 1'b1, 2'b11, 8'hAA, 3'b010};
        tbl[2] = '{8'hAA, 1'b0, 2'b00, 8'hAA, 3'b100};
        tbl[3] = '{8'h00, 1'b0, 2'b00, 8'h00, 3'b001};
        tbl[4] = '{8'h3C, 1'b0, 2'b11, 8'h3C, 3'b000};
        tbl[5] = '{8'hAA, 1'b1, 2'b00, 8'hAA, 3'b110};
        tbl[6] = '{8'h00, 1'b1, 2'b00, 8'h00, 3'b110};
        tbl[7] = '{8'h81, 1'b0, 2'b10, 8'h81, 3'b100};

        Rx = 1'b1;
        Rst_n = 1'b0;
        repeat (5) @(negedge Clk);
        check("reset_data_out", 32'(rx_if.Data_Out), 32'h00);
        check("reset_rx_error", 32'(rx_if.Rx_Error), 32'h0);
        check("reset_data_rdy", 32'(rx_if.Data_Rdy), 32'h0);
        check("reset_rx_busy",  32'(rx_if.Rx_Busy),  32'h0);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({tbl[i].exp_err, tbl[i].exp_data});
            send_frame(tbl[i].data, tbl[i].par, tbl[i].st);
            repeat (2 * BIT) @(negedge Clk);
            drain($sformatf("table_%0d", i));
            if (i == 0) check("busy_len_1760", 32'(last_busy >= 1756 && last_busy <= 1764), 32'd1);
        end

        // Break, a start edge during recovery, then a clean character.
        exp_q.push_back({3'b001, 8'h00});
        send_frame(8'h00, 1'b0, 2'b00);
        rises0 = busy_rises;
        repeat (80) @(negedge Clk);
        Rx = 1'b0;
        repeat (BIT) @(negedge Clk);
        Rx = 1'b1;
        repeat (400) @(negedge Clk);
        drain("break");
        check("brkwait_ignores_start", 32'(busy_rises - rises0), 32'd0);
        exp_q.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 1'b0, 2'b11);
        repeat (2 * BIT) @(negedge Clk);
        drain("after_break");

        // 40-clock glitch, then two back-to-back frames.
        rises0 = busy_rises;
        Rx = 1'b0;
        repeat (40) @(negedge Clk);
        Rx = 1'b1;
        repeat (200) @(negedge Clk);
        check("glitch_busy", 32'(busy_rises - rises0), 32'd0);
        check("glitch_rdy", 32'(got_wr - got_rd), 32'd0);
        exp_q.push_back({3'b000, 8'h01});
        exp_q.push_back({3'b000, 8'hFE});
        send_frame(8'h01, 1'b1, 2'b11);
        send_frame(8'hFE, 1'b1, 2'b11);
        repeat (2 * BIT) @(negedge Clk);
        drain("back_to_back");

        // Reset during the data bits of 0x55.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        Rx = 1'b0;
        repeat (60) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midrst_data_out", 32'(rx_if.Data_Out), 32'h00);
        check("midrst_rx_error", 32'(rx_if.Rx_Error), 32'h0);
        check("midrst_data_rdy", 32'(rx_if.Data_Rdy), 32'h0);
        check("midrst_rx_busy",  32'(rx_if.Rx_Busy),  32'h0);
        Rx = 1'b1;
        repeat (20) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2 * BIT) @(negedge Clk);
        drain("midrst_no_rdy");
        exp_q.push_back({3'b000, 8'hC3});
        send_frame(8'hC3, 1'b0, 2'b11);
        repeat (2 * BIT) @(negedge Clk);
        drain("after_reset");

        // Randomized frames against the reference model.
        for (int n = 0; n < 14; n++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 6) == 0) begin
                d = 8'h00;
                p = 1'b0;
                s = 2'b00;
            end
            exp_q.push_back(model(d, p, s));
            send_frame(d, p, s);
            repeat (400) @(negedge Clk);
            drain($sformatf("random_%0d", n));
        end

        check("no_consecutive_rdy", 32'(consec_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial receive engine for the UART: oversamples the asynchronous `Rx` line, recovers framed characters (start, data MSB-first, optional even parity, stop bits) and presents each character with a one-cycle ready strobe and error flags to the receive FIFO. It is the receiving counterpart of the UART transmitter, and its frame format is bit-for-bit identical to the one the transmitter emits. It sits between the `Rx` pin and the FIFO push port.

## Interface

- `SYSCLK_RATE`, 100000000: `Clk` frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit. Must be an even number of at least 4.
- `DATA_BITS`, 8: data bits per character, 1–8.
- `PARITY_BIT`, 1: 1 means an even-parity bit follows the data; 0 means there is none.
- `STOP_BITS`, 2: stop bits per frame, 1–2.

- `Clk` input, 1: single clock. Everything is on posedge.
- `Rst_n` input, 1: asynchronous, active-low reset.
- `Rx` input, 1: serial line, asynchronous, idles high.
- `Data_Out` output, DATA_BITS: last received character. Held between frames.
- `Data_Rdy` output, 1: one-cycle strobe; `Data_Out` and `Rx_Error` are valid with it.
- `Rx_Error` output, 3: [0] break, [1] parity, [2] frame. Updated with `Data_Rdy`.
- `Rx_Busy` output, 1: high from a confirmed start bit until the frame completes or is aborted.

## Operation

- **Input synchronizer.** `Rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Tick generator.**
  - DIV = SYSCLK_RATE / (BAUD_RATE × OVERSAMPLE), integer division. Minimum value is 1.
  - A counter of width clog2(DIV) raises a one-cycle `tick` every DIV clocks.
  - The counter free-runs except in IDLE, where it is held at 0 so that ticks align to the start edge.
- **States.**
  - IDLE: on `rx_s`=0, go to START and clear the sample counter.
  - START: count ticks. At tick OVERSAMPLE/2 (the bit midpoint), if `rx_s`=0, set `Rx_Busy` and go to DATA. Otherwise this is a false start: return to IDLE with `Rx_Busy` left at 0.
  - DATA: sample at the midpoint of each bit, OVERSAMPLE ticks apart. Shift in MSB first. After DATA_BITS samples, go to PARITY if PARITY_BIT=1, else to STOP.
  - PARITY: one sample. Parity error = sample ≠ XOR of the data bits.
  - STOP: STOP_BITS samples. Frame error if any stop sample is 0. After the last stop sample, go to DONE.
  - DONE, one cycle:
    - Load `Data_Out` and `Rx_Error`, and pulse `Data_Rdy`.
    - Clear `Rx_Busy`.
    - If break, go to BRKWAIT; otherwise go to IDLE.
  - BRKWAIT: wait until `rx_s` has been 1 for OVERSAMPLE consecutive ticks, then go to IDLE. No start detection happens in this state.
- **Error classification.**
  - Break: every sampled bit is 0, i.e. data, parity (if present) and all stops. Result is `Rx_Error`=3'b001 and `Data_Out`=0. The frame flag is suppressed.
  - Otherwise parity and frame errors are independent, and a frame may report 3'b110.
- **Corrupt characters.** A character with errors is still delivered with `Data_Rdy`. Discarding it is the FIFO's decision.
- **Reset.**
  - `Rst_n` low at any time, including mid-frame, gives state IDLE, `Data_Out`=0, `Data_Rdy`=0, `Rx_Error`=3'b000, `Rx_Busy`=0.
  - The partial frame is discarded. No `Data_Rdy` is produced for it.

## Timing

- **Bit period.** DIV × OVERSAMPLE clocks.
- **Start confirmation.** OVERSAMPLE/2 ticks after `rx_s` falls. `rx_s` lags `Rx` by 2 clocks.
- **`Data_Rdy` latency.** `Data_Rdy` is asserted exactly 1 clock after the tick that samples the final stop bit. It is therefore about half a bit period before the end of the frame on the line.
- **Frame length.** 1 + DATA_BITS + PARITY_BIT + STOP_BITS bits. With defaults that is 12 bits.
- **Back-to-back frames.** A start edge arriving in the cycle after DONE is detected normally. The engine returns to IDLE before the end of the last stop bit, so there are no dead cycles at full line rate.
- **`Data_Rdy`.** Never asserted on two consecutive cycles.
- **Held outputs.** `Data_Out` and `Rx_Error` are held until the next DONE.

## Test plan

All scenarios use SYSCLK_RATE=1600000, BAUD_RATE=10000 and OVERSAMPLE=16, giving DIV=10 and a bit period of 160 clocks. Defaults apply otherwise.

- **Clean frame.** Send 0xA5 MSB-first with parity 0 and two stop bits of 1. Expect `Data_Out`=0xA5, `Rx_Error`=000, exactly one `Data_Rdy`, and `Rx_Busy` high for about 1760 clocks.
- **Parity error.** Send 0xAA with parity 1 (wrong). Expect `Data_Out`=0xAA and `Rx_Error`=010.
- **Frame error.** Send 0xAA with correct parity 0 and both stop bits 0. Expect `Rx_Error`=100.
- **Break, then recovery.**
  - Hold `Rx` low for 12 bits, then high. Expect `Rx_Error`=001 and `Data_Out`=0x00.
  - A start edge driven within 160 clocks of `Rx` rising must be ignored.
  - Then send 0x3C cleanly. Expect `Data_Out`=0x3C and `Rx_Error`=000.
- **Glitch and back-to-back.**
  - Drive `Rx` low for 40 clocks. Expect no `Rx_Busy` and no `Data_Rdy`.
  - Then send two back-to-back frames, 0x01 and 0xFE. Expect two `Data_Rdy` strobes carrying those values in order.
- **Reset mid-frame.** Assert `Rst_n` low during the data bits of 0x55. Expect all outputs at their reset values immediately and no `Data_Rdy` for 0x55. A following frame 0xC3 is received with `Rx_Error`=000.
